// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared state encoding and sizing helpers for seq_divider
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter must be able to hold WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_divider_fadder.sv
// rtl/seq_divider_fadder.sv - WIDTH-bit adder/subtractor with carry in/out
module seq_divider_fadder #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub_enable,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   total;

  // With sub_enable and carry_in set this is a - b; carry_out=1 means no borrow.
  assign b_eff = b ^ {WIDTH{sub_enable}};
  assign total = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};

  assign sum       = total[WIDTH-1:0];
  assign carry_out = total[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative unsigned restoring divider, one quotient bit per clock
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH:0]   p_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;

  logic             accept;
  logic             divisor_zero;
  logic             last_iter;
  logic [WIDTH:0]   ps;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   p_next;
  logic [WIDTH-1:0] a_next;
  logic             no_borrow;
  logic             p_msb_unused;

  assign accept       = start && (state_q != RUN);
  assign divisor_zero = (divisor == '0);
  assign last_iter    = (cnt_q == CNT_W'(WIDTH - 1));

  // Shift the next dividend bit into the partial remainder and trial-subtract D.
  assign ps = {p_q[WIDTH-1:0], a_q[WIDTH-1]};

  seq_divider_fadder #(
    .WIDTH (WIDTH + 1)
  ) u_fadder (
    .a          (ps),
    .b          ({1'b0, d_q}),
    .sub_enable (1'b1),
    .carry_in   (1'b1),
    .sum        (diff),
    .carry_out  (no_borrow)
  );

  assign p_next = no_borrow ? diff : ps;
  assign a_next = {a_q[WIDTH-2:0], no_borrow};

  // P stays below D after every restoring step, so its top bit never feeds back.
  assign p_msb_unused = p_q[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = divisor_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_d = divisor_zero ? DONE : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      d_q         <= '0;
      p_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else if (accept) begin
      a_q   <= dividend;
      d_q   <= divisor;
      p_q   <= '0;
      cnt_q <= '0;
      if (divisor_zero) begin
        quotient_q  <= '1;
        remainder_q <= dividend;
        dbz_q       <= 1'b1;
      end
    end else if (state_q == RUN) begin
      a_q   <= a_next;
      p_q   <= p_next;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last_iter) begin
        quotient_q  <= a_next;
        remainder_q <= p_next[WIDTH-1:0];
        dbz_q       <= 1'b0;
      end
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider against a latency/arithmetic model
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted start yields W busy cycles then a done cycle (or done at once on /0).
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_q = '0, m_r = '0, m_pq = '0, m_pr = '0;
  logic         m_z = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_done = 1'b0; m_q = '0; m_r = '0; m_z = 1'b0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      m_done = (m_left == 0);
      if (m_done) begin
        m_q = m_pq; m_r = m_pr; m_z = 1'b0;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        if (divisor == 0) begin
          m_done = 1'b1; m_q = '1; m_r = dividend; m_z = 1'b1;
        end else begin
          m_left = W; m_pq = dividend / divisor; m_pr = dividend % divisor;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("busy", busy, m_left > 0);
    check("done", done, m_done);
    check("quotient", quotient, m_q);
    check("remainder", remainder, m_r);
    check("div_by_zero", div_by_zero, m_z);
  end

  task automatic drive(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk);
    #2;
    start = s; dividend = a; divisor = b;
  endtask

  // Counts cycles after the accepting edge until done; returns at the done-cycle negedge.
  task automatic wait_done(input bit scramble, output int cyc);
    cyc = 0;
    while (cyc < 4 * W) begin
      @(negedge clk);
      if (done) break;
      if (scramble) begin
        dividend = $urandom; divisor = $urandom;
      end
      cyc++;
    end
    if (cyc >= 4 * W) check("done_timeout", done, 1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic ez, input int elat, input int gap);
    int cyc;
    drive(1'b1, a, b);
    @(posedge clk);
    #2;
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    wait_done(1'b0, cyc);
    check("latency", cyc, elat);
    check("lit_quotient", quotient, eq);
    check("lit_remainder", remainder, er);
    check("lit_div_by_zero", div_by_zero, ez);
    if (b != 0) check("rem_lt_div", remainder < b, 1);
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int cyc, cyc2, seen;
    logic [W-1:0] a, b;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(100, 7, 14, 2, 0, W, 1);
    run_op(255, 1, 255, 0, 0, W, 0);
    run_op(5, 9, 0, 5, 0, W, 2);
    run_op(200, 200, 1, 0, 0, W, 0);
    run_op(42, 0, 255, 42, 1, 0, 1);
    run_op(9, 4, 2, 1, 0, W, 1);

    // Start held high; operands wander during RUN and switch in the DONE cycle.
    drive(1'b1, 77, 5);
    @(posedge clk);
    #2;
    dividend = $urandom; divisor = $urandom;
    wait_done(1'b1, cyc);
    check("b2b_lat", cyc, W);
    check("b2b_q1", quotient, 15);
    check("b2b_r1", remainder, 2);
    dividend = 13; divisor = 3;
    wait_done(1'b1, cyc2);
    start = 1'b0;
    check("b2b_spacing", cyc2 + 1, W + 1);
    check("b2b_q2", quotient, 4);
    check("b2b_r2", remainder, 1);
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of an operation.
    drive(1'b1, 100, 7);
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    check("async_quotient", quotient, 0);
    check("async_remainder", remainder, 0);
    check("async_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (2 * W) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("no_done_after_reset", seen, 0);
    run_op(100, 7, 14, 2, 0, W, 0);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 0;
        1:       b = $urandom_range(1, 3);
        default: b = $urandom;
      endcase
      if (b == 0) run_op(a, b, '1, a, 1, 0, $urandom_range(0, 2));
      else        run_op(a, b, a / b, a % b, 0, W, $urandom_range(0, 2));
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
